mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and sequencer in front of the 32x8 single-port `mem` block. Two requesters (port 0 and port 1) each issue single read or write transactions. The arbiter picks one with round-robin fairness and drives the memory's `read`/`write`/`addr`/`data_i` command until `ack`. It then returns read data and a one-cycle completion pulse to the winner. It sits between the memory and its clients in the same top-level, replacing direct bench drive of the memory pins.

## Interface
Parameters:
- `ADDR_W`, 5, memory address width (32 words)
- `DATA_W`, 8, memory data width
- `TIMEOUT`, 15, max cycles waiting for `ack` (used only with the timeout feature)

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous active-high reset
- `req0`, `req1`  in  1  transaction request, level, held until own `done`
- `we0`, `we1`  in  1  1 = write, 0 = read; stable while `req` high
- `addr0`, `addr1`  in  ADDR_W  address; stable while `req` high
- `wdata0`, `wdata1`  in  DATA_W  write data; stable while `req` high
- `done0`, `done1`  out  1  one-cycle completion pulse
- `err0`, `err1`  out  1  qualifies `done`: transaction timed out
- `rdata`  out  DATA_W  read data, valid when `done0`/`done1` is high for a read
- `busy`  out  1  high in any state other than IDLE
- `read`, `write`  out  1  memory command strobes, never both high
- `addr`  out  ADDR_W  memory address
- `data_i`  out  DATA_W  memory write data
- `data_o`  in  DATA_W  memory read data
- `ack`  in  1  memory completion

## Operation
- FSM states: IDLE, CMD, RESP.
- IDLE:
  - If any `req` is high, select a winner, latch its `we`/`addr`/`wdata` and go to CMD.
  - `read` or `write` (per `we`), `addr` and `data_i` are registered and asserted at that same edge.
- Round-robin:
  - `last_gnt` register, reset to 1, so port 0 wins first.
  - If both requests are high, the port != `last_gnt` wins.
  - A single request wins regardless of `last_gnt`.
  - `last_gnt` updates at the IDLE->CMD edge.
- CMD:
  - Hold the command and latched fields unchanged until `ack` is sampled high.
  - On `ack`: clear `read`/`write` (and `addr`/`data_i` to 0) and go to RESP.
  - On a read, capture `data_o` into `rdata` at the same edge.
- RESP:
  - Winner's `done` is high for exactly one cycle; go to IDLE.
  - `rdata` holds until the next read completes.
- Requester contract: drop `req` at the edge where `done` is sampled high. The arbiter never re-grants a port during its own `done` cycle.
- A request arriving during CMD/RESP waits; it is never lost.
- `ack` sampled in IDLE or RESP is ignored.
- Reset, including mid-transaction:
  - All outputs go to 0 (`read`, `write`, `addr`, `data_i`, `rdata`, `done*`, `err*`, `busy`).
  - State returns to IDLE, `last_gnt` returns to 1, and any in-flight transaction is dropped with no `done`.

## Timing
- Request high before edge e: command asserted after edge e.
- `ack` high before edge a: `done` is high in cycle a..a+1.
- Earliest next command is after edge a+2.
- Minimum transaction is 3 cycles, given `ack` one cycle after the command.
- Read data appears on `rdata` the same cycle as `done`.
- All outputs are registered; no combinational path from `req*`/`ack` to outputs.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - Cycle counter runs in CMD, cleared on entry.
  - When it reaches `TIMEOUT` with no `ack`: drop the command and go to RESP.
  - Pulse the winner's `done` with its `err` high; `rdata` is unchanged.
  - If `ack` and the timeout occur on the same edge, `ack` wins (normal completion, `err` = 0).
- Not defined: no counter, CMD waits indefinitely, and `err0`/`err1` are tied 0. Ports are identical in both builds.

## Structure
- Package `mem_arb_pkg`: `arb_state_e` enum (IDLE, CMD, RESP), `ADDR_W`/`DATA_W`/`TIMEOUT` default localparams.
- Sub-module `mem_arb_rr`: owns `last_gnt`. Inputs are `req0`, `req1`, `take`; outputs are `gnt_sel` and `gnt_vld`. Keeps the fairness logic separately testable.

## Test plan
- Port 0 writes 0xA5 to addr 3, then port 1 reads addr 3: memory sees exactly one `write` then one `read`, `done1` has `rdata` = 0xA5, `done0` pulses once.
- `req0` and `req1` both high from reset, both reads: port 0 served first, then port 1. Re-asserting both serves port 0 then port 1 again (alternation).
- Port 1 holds `req` continuously for 4 transactions while `req0` pulses once mid-stream: port 0 is served immediately after the current port 1 transaction.
- Memory delays `ack` 6 cycles: command pins stay stable for all 6 cycles, `done` comes exactly 1 cycle after `ack`, `read` and `write` are never both high.
- `rst` asserted while in CMD: all outputs 0 by the next sample, no `done`, and the next request after release is served with port 0 priority.
- With `MEM_ARB_TIMEOUT_EN` and `ack` never asserted: after 15 CMD cycles the command drops and `done0` = `err0` = 1. With the macro off, the same stimulus keeps `busy` high indefinitely.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Client and memory-side signal bundle for mem_arbiter; slave is the arbiter's view.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = mem_arb_pkg::ADDR_W,
    parameter int DATA_W = mem_arb_pkg::DATA_W
);
    // Handshake: a client raises reqN with weN/addrN/wdataN stable and holds it
    // until doneN is sampled high, dropping req at that same edge. On the memory
    // side read/write stay asserted with addr/data_i stable until ack is sampled.
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              done0;
    logic              done1;
    logic              err0;
    logic              err1;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_i;
    logic [DATA_W-1:0] data_o;
    logic              ack;
    arb_state_e        dbg_state;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, data_o, ack,
        output done0, done1, err0, err1, rdata, busy, read, write, addr, data_i,
               dbg_state
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, data_o, ack,
        input  done0, done1, err0, err1, rdata, busy, read, write, addr, data_i,
               dbg_state
    );

endinterface

// File: rtl/mem_arb_rr.sv
// Round-robin grant selection between two requesters; remembers the last winner.
module mem_arb_rr (
    input  logic clk,
    input  logic rst,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_take,
    output logic o_gnt_sel,
    output logic o_gnt_vld
);

    // Reset to port 1 so that port 0 wins the first contested grant.
    logic r_last_gnt;

    always_comb begin
        o_gnt_vld = i_req0 | i_req1;
        if (i_req0 && i_req1) begin
            o_gnt_sel = ~r_last_gnt;
        end else begin
            o_gnt_sel = i_req1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_gnt <= 1'b1;
        end else if (i_take) begin
            r_last_gnt <= o_gnt_sel;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single-port memory.
// Optional ack timeout is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = mem_arb_pkg::ADDR_W,
    parameter int DATA_W  = mem_arb_pkg::DATA_W,
    parameter int TIMEOUT = mem_arb_pkg::TIMEOUT
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic              r_read;
    logic              w_read_nxt;
    logic              r_write;
    logic              w_write_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] r_data_i;
    logic [DATA_W-1:0] w_data_i_nxt;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] w_rdata_nxt;
    logic              r_done0;
    logic              w_done0_nxt;
    logic              r_done1;
    logic              w_done1_nxt;
    logic              r_busy;
    logic              r_gnt;
    logic              w_gnt_nxt;
    logic              w_take;
    logic              w_gnt_sel;
    logic              w_gnt_vld;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_err_nxt;
    logic              r_err0;
    logic              r_err1;
`endif

    mem_arb_rr u_rr (
        .clk       (clk),
        .rst       (rst),
        .i_req0    (bus.req0),
        .i_req1    (bus.req1),
        .i_take    (w_take),
        .o_gnt_sel (w_gnt_sel),
        .o_gnt_vld (w_gnt_vld)
    );

    assign w_sel_we    = w_gnt_sel ? bus.we1    : bus.we0;
    assign w_sel_addr  = w_gnt_sel ? bus.addr1  : bus.addr0;
    assign w_sel_wdata = w_gnt_sel ? bus.wdata1 : bus.wdata0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The command registers double as the latched request fields while in CMD.
    always_comb begin
        w_state_nxt  = r_state;
        w_read_nxt   = r_read;
        w_write_nxt  = r_write;
        w_addr_nxt   = r_addr;
        w_data_i_nxt = r_data_i;
        w_rdata_nxt  = r_rdata;
        w_done0_nxt  = 1'b0;
        w_done1_nxt  = 1'b0;
        w_gnt_nxt    = r_gnt;
        w_take       = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        w_cnt_nxt    = r_cnt;
        w_err_nxt    = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_gnt_vld) begin
                    w_take       = 1'b1;
                    w_gnt_nxt    = w_gnt_sel;
                    w_read_nxt   = ~w_sel_we;
                    w_write_nxt  = w_sel_we;
                    w_addr_nxt   = w_sel_addr;
                    w_data_i_nxt = w_sel_wdata;
                    w_state_nxt  = CMD;
`ifdef MEM_ARB_TIMEOUT_EN
                    w_cnt_nxt    = '0;
`endif
                end
            end
            CMD: begin
                if (bus.ack) begin
                    w_read_nxt   = 1'b0;
                    w_write_nxt  = 1'b0;
                    w_addr_nxt   = '0;
                    w_data_i_nxt = '0;
                    if (r_read) begin
                        w_rdata_nxt = bus.data_o;
                    end
                    w_done0_nxt  = ~r_gnt;
                    w_done1_nxt  = r_gnt;
                    w_state_nxt  = RESP;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_read_nxt   = 1'b0;
                    w_write_nxt  = 1'b0;
                    w_addr_nxt   = '0;
                    w_data_i_nxt = '0;
                    w_done0_nxt  = ~r_gnt;
                    w_done1_nxt  = r_gnt;
                    w_err_nxt    = 1'b1;
                    w_state_nxt  = RESP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
`endif
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_read   <= 1'b0;
            r_write  <= 1'b0;
            r_addr   <= '0;
            r_data_i <= '0;
            r_rdata  <= '0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_busy   <= 1'b0;
            r_gnt    <= 1'b0;
        end else begin
            r_read   <= w_read_nxt;
            r_write  <= w_write_nxt;
            r_addr   <= w_addr_nxt;
            r_data_i <= w_data_i_nxt;
            r_rdata  <= w_rdata_nxt;
            r_done0  <= w_done0_nxt;
            r_done1  <= w_done1_nxt;
            r_busy   <= (w_state_nxt != IDLE);
            r_gnt    <= w_gnt_nxt;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_err0 <= 1'b0;
            r_err1 <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_err0 <= w_err_nxt & w_done0_nxt;
            r_err1 <= w_err_nxt & w_done1_nxt;
        end
    end

    assign bus.err0 = r_err0;
    assign bus.err1 = r_err1;
`else
    assign bus.err0 = 1'b0;
    assign bus.err1 = 1'b0;
`endif

    assign bus.read      = r_read;
    assign bus.write     = r_write;
    assign bus.addr      = r_addr;
    assign bus.data_i    = r_data_i;
    assign bus.rdata     = r_rdata;
    assign bus.done0     = r_done0;
    assign bus.done1     = r_done1;
    assign bus.busy      = r_busy;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural 32x8 memory answering ack.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int EXP_W = 11;  // {port, err, check_rdata, rdata}

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [EXP_W-1:0] exp_q[$];

    logic [7:0] mem [32];
    int   ack_dly     = 0;
    bit   mem_hold    = 1'b0;
    int   wait_cnt    = 0;
    int   hold_cycles = 0;
    int   cyc         = 0;
    int   ack_cyc     = -10;
    int   wr_acks     = 0;
    int   rd_acks     = 0;
    int   done0_cnt   = 0;
    int   done1_cnt   = 0;
    logic [15:0] cap_cmd;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic push_exp(input bit p, input bit err, input bit chk, input logic [7:0] d);
        exp_q.push_back({p, err, chk, d});
    endtask

    task automatic port_txn(input bit p, input bit we, input logic [4:0] a, input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        if (!p) begin
            bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; bus.req0 = 1'b1;
        end else begin
            bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; bus.req1 = 1'b1;
        end
        forever begin
            @(negedge clk);
            if ((p ? bus.done1 : bus.done0) === 1'b1) break;
            n++;
            if (n > 200) begin
                n_checks++;
                n_errors++;
                $display("FAIL txn_timeout port%0d: no done after %0d cycles, expected done", p, n);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!p) bus.req0 = 1'b0;
        else    bus.req1 = 1'b0;
    endtask

    // Cycle counter
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory model: acks ack_dly negedges after first seeing a command
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'(8'h10 + i);
        bus.ack    = 1'b0;
        bus.data_o = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.ack  = 1'b0;
                wait_cnt = 0;
                continue;
            end
            if (bus.read || bus.write)
                check("rd_wr_exclusive", 32'(bus.read & bus.write), 32'd0);
            if (bus.ack) begin
                bus.ack  = 1'b0;
                wait_cnt = 0;
            end else if (bus.read || bus.write) begin
                if (wait_cnt == 0)
                    cap_cmd = {bus.read, bus.write, 1'b0, bus.addr, bus.data_i};
                else
                    check("cmd_stable", 32'({bus.read, bus.write, 1'b0, bus.addr, bus.data_i}), 32'(cap_cmd));
                hold_cycles = wait_cnt + 1;
                if (!mem_hold && wait_cnt == ack_dly) begin
                    bus.ack = 1'b1;
                    ack_cyc = cyc;
                    if (bus.write) begin
                        mem[bus.addr] = bus.data_i;
                        wr_acks++;
                    end else begin
                        rd_acks++;
                    end
                    bus.data_o = mem[bus.addr];
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: pops one expected response per done pulse
    initial forever begin
        logic [EXP_W-1:0] exp_v;
        logic [EXP_W-1:0] got_v;
        @(negedge clk);
        if (!rst && (bus.done0 || bus.done1)) begin
            check("done_onehot", 32'(bus.done0 & bus.done1), 32'd0);
            if (bus.done0) done0_cnt++;
            if (bus.done1) done1_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: got done0=%0b done1=%0b expected no done", bus.done0, bus.done1);
            end else begin
                exp_v = exp_q.pop_front();
                got_v = {bus.done1, (bus.done1 ? bus.err1 : bus.err0), exp_v[8],
                         (exp_v[8] ? bus.rdata : 8'h00)};
                check("resp", 32'(got_v), 32'(exp_v));
                if (!got_v[9]) check("ack_to_done", 32'(cyc), 32'(ack_cyc + 1));
            end
        end
    end

    // Watchdog
    initial begin
        #1000000;
        n_errors++;
        $display("FAIL watchdog: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({bus.read, bus.write, bus.addr, bus.data_i, bus.rdata,
                                    bus.done0, bus.done1, bus.err0, bus.err1, bus.busy}), 32'd0);
        check("reset_state", 32'(bus.dbg_state), 32'(IDLE));
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_release", 32'({bus.busy, bus.read, bus.write}), 32'd0);

        // Both reads from reset: port 0 first, then alternation again
        push_exp(1'b0, 1'b0, 1'b1, 8'h17);
        push_exp(1'b1, 1'b0, 1'b1, 8'h19);
        fork
            port_txn(1'b0, 1'b0, 5'd7, 8'h00);
            port_txn(1'b1, 1'b0, 5'd9, 8'h00);
        join
        push_exp(1'b0, 1'b0, 1'b1, 8'h1A);
        push_exp(1'b1, 1'b0, 1'b1, 8'h1B);
        fork
            port_txn(1'b0, 1'b0, 5'd10, 8'h00);
            port_txn(1'b1, 1'b0, 5'd11, 8'h00);
        join

        // Port 0 writes A5 to addr 3, port 1 reads it back
        wr_acks = 0; rd_acks = 0; done0_cnt = 0;
        push_exp(1'b0, 1'b0, 1'b0, 8'h00);
        port_txn(1'b0, 1'b1, 5'd3, 8'hA5);
        push_exp(1'b1, 1'b0, 1'b1, 8'hA5);
        port_txn(1'b1, 1'b0, 5'd3, 8'h00);
        check("one_write", 32'(wr_acks), 32'd1);
        check("one_read", 32'(rd_acks), 32'd1);
        check("done0_once", 32'(done0_cnt), 32'd1);

        // Port 1 streams 4 reads; port 0 write cuts in after the first
        push_exp(1'b1, 1'b0, 1'b1, 8'h11);
        push_exp(1'b0, 1'b0, 1'b0, 8'h00);
        push_exp(1'b1, 1'b0, 1'b1, 8'h12);
        push_exp(1'b1, 1'b0, 1'b1, 8'h14);
        push_exp(1'b1, 1'b0, 1'b1, 8'h15);
        fork
            begin
                port_txn(1'b1, 1'b0, 5'd1, 8'h00);
                port_txn(1'b1, 1'b0, 5'd2, 8'h00);
                port_txn(1'b1, 1'b0, 5'd4, 8'h00);
                port_txn(1'b1, 1'b0, 5'd5, 8'h00);
            end
            begin
                repeat (2) @(negedge clk);
                port_txn(1'b0, 1'b1, 5'd30, 8'h5A);
            end
        join

        // Slow memory: ack after 6 waiting cycles
        ack_dly = 6;
        push_exp(1'b0, 1'b0, 1'b0, 8'h00);
        port_txn(1'b0, 1'b1, 5'd20, 8'h3C);
        push_exp(1'b1, 1'b0, 1'b1, 8'h3C);
        port_txn(1'b1, 1'b0, 5'd20, 8'h00);
        check("slow_hold_cycles", 32'(hold_cycles), 32'd7);
        ack_dly = 0;

        // Reset while port 0 is in CMD
        mem_hold = 1'b1;
        @(negedge clk);
        bus.we0 = 1'b0; bus.addr0 = 5'd6; bus.req0 = 1'b1;
        repeat (3) @(negedge clk);
        check("in_cmd_before_reset", 32'(bus.dbg_state), 32'(CMD));
        #2;
        rst = 1'b1;
        bus.req0 = 1'b0;
        mem_hold = 1'b0;
        @(negedge clk);
        check("midcmd_reset_outputs", 32'({bus.read, bus.write, bus.addr, bus.data_i, bus.rdata,
                                           bus.done0, bus.done1, bus.err0, bus.err1, bus.busy}), 32'd0);
        check("midcmd_reset_state", 32'(bus.dbg_state), 32'(IDLE));
        rst = 1'b0;
        push_exp(1'b0, 1'b0, 1'b0, 8'h00);
        push_exp(1'b1, 1'b0, 1'b0, 8'h00);
        fork
            port_txn(1'b0, 1'b1, 5'd12, 8'h66);
            port_txn(1'b1, 1'b1, 5'd13, 8'h77);
        join
        push_exp(1'b0, 1'b0, 1'b1, 8'h66);
        port_txn(1'b0, 1'b0, 5'd12, 8'h00);

        // Memory never acks
`ifdef MEM_ARB_TIMEOUT_EN
        mem_hold = 1'b1;
        push_exp(1'b0, 1'b1, 1'b1, 8'h66);
        port_txn(1'b0, 1'b0, 5'd8, 8'h00);
        check("timeout_hold_cycles", 32'(hold_cycles), 32'd15);
        mem_hold = 1'b0;
        @(negedge clk);
        check("timeout_idle_after", 32'({bus.busy, bus.read, bus.err0}), 32'd0);
`else
        mem_hold = 1'b1;
        @(negedge clk);
        bus.we0 = 1'b0; bus.addr0 = 5'd8; bus.req0 = 1'b1;
        repeat (40) @(negedge clk);
        check("no_timeout_busy", 32'({bus.busy, bus.read, bus.done0}), 32'b110);
        rst = 1'b1;
        bus.req0 = 1'b0;
        mem_hold = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("no_timeout_recovered", 32'(bus.busy), 32'd0);
`endif

        repeat (5) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
